// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the bypassing multi-port register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    // When both write ports target the same register, port 0 (ALU writeback) is kept.
    localparam bit PORT0_WINS = 1'b1;

    // Bit offset of port k inside a packed multi-port bus whose fields are w bits wide.
    function automatic int port_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register plus a running count of set bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                clr_valid,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] pending,
    output logic [ADDR_W:0]     pending_count
);

    logic set_ok;
    logic clr_ok;
    logic set_new;
    logic clr_new;

    // set_new/clr_new are real 0->1 / 1->0 transitions, so the counter tracks
    // popcount(pending) with a +1/0/-1 step instead of a full recount.
    always_comb begin
        set_ok  = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));
        clr_ok  = clr_valid && !((ZERO_REG != 0) && (clr_addr == '0));
        set_new = set_ok && !pending[issue_addr];
        clr_new = clr_ok && pending[clr_addr] && !(set_ok && (issue_addr == clr_addr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            // Clear first so a same-register issue overrides the returning load.
            if (clr_ok) pending[clr_addr] <= 1'b0;
            if (set_ok) pending[issue_addr] <= 1'b1;
            if (set_new && !clr_new)
                pending_count <= pending_count + (ADDR_W + 1)'(1);
            else if (clr_new && !set_new)
                pending_count <= pending_count - (ADDR_W + 1)'(1);
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Dual-write, multi-read register file with write-to-read bypass and a pending-load scoreboard.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          pending_count,
    output logic                     conflict_err
);

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                w0_ok;
    logic                w1_ok;
    logic                conflict;

    // Writes to the hardwired zero register are dropped before any other logic sees them.
    always_comb begin
        w0_ok    = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
        w1_ok    = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
        conflict = w0_ok && w1_ok && (waddr0 == waddr1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            conflict_err <= 1'b0;
        end else begin
            // The later non-blocking assignment wins on an address collision.
            if (PORT0_WINS) begin
                if (w1_ok) mem[waddr1] <= wdata1;
                if (w0_ok) mem[waddr0] <= wdata0;
            end else begin
                if (w0_ok) mem[waddr0] <= wdata0;
                if (w1_ok) mem[waddr1] <= wdata1;
            end
            if (conflict) conflict_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;
        logic              hit0;
        logic              hit1;
        logic              zero_hit;

        assign addr = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

        always_comb begin
            zero_hit = (ZERO_REG != 0) && (addr == '0);
            hit0     = w0_ok && (waddr0 == addr);
            hit1     = w1_ok && (waddr1 == addr);
            data     = mem[addr];
            if (PORT0_WINS) begin
                if (hit1) data = wdata1;
                if (hit0) data = wdata0;
            end else begin
                if (hit0) data = wdata0;
                if (hit1) data = wdata1;
            end
            // Pending shows registered state only; bypass never changes it.
            pend = pending[addr];
            if (reset || zero_hit) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
        assign rd_pending[k]                          = pend;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .clr_valid     (we1),
        .clr_addr      (waddr1),
        .pending       (pending),
        .pending_count (pending_count)
    );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed plus randomised bench for regfile_bypass with a reference model and expected queue.
module tb_regfile_bypass;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int ADDR_W   = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic                     we0, we1, issue_valid;
    logic [ADDR_W-1:0]        waddr0, waddr1, issue_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [ADDR_W:0]          pending_count;
    logic                     conflict_err;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_pending    (rd_pending),
        .we0           (we0),
        .waddr0        (waddr0),
        .wdata0        (wdata0),
        .we1           (we1),
        .waddr1        (waddr1),
        .wdata1        (wdata1),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .pending_count (pending_count),
        .conflict_err  (conflict_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    logic [DATA_W-1:0]   model_mem [NUM_REGS];
    logic [NUM_REGS-1:0] model_pend;
    logic                model_conf;

    logic [DATA_W-1:0] exp_q[$];
    int checks = 0;
    int fails  = 0;

    // scoreboard
    task automatic check(input string tag, input logic [DATA_W-1:0] obs);
        logic [DATA_W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (reset || a == '0) return '0;
        if (we0 && waddr0 == a) return wdata0;
        if (we1 && waddr1 == a) return wdata1;
        return model_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        if (reset || a == '0) return 1'b0;
        return model_pend[a];
    endfunction

    // driver tasks
    task automatic idle();
        we0 = 0; we1 = 0; issue_valid = 0;
        waddr0 = '0; waddr1 = '0; issue_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic check_port(input string tag, input int k);
        logic [ADDR_W-1:0] a;
        a = rd_addr[k*ADDR_W +: ADDR_W];
        exp_q.push_back(exp_data(a));
        exp_q.push_back(DATA_W'(exp_pend(a)));
        #1;
        check({tag, "_data"}, rd_data[k*DATA_W +: DATA_W]);
        check({tag, "_pend"}, DATA_W'(rd_pending[k]));
    endtask

    // One rising edge: update the model from the driven inputs, then check registered outputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
            model_pend = '0;
            model_conf = 1'b0;
        end else begin
            if (we0 && we1 && waddr0 == waddr1 && waddr0 != '0) model_conf = 1'b1;
            if (we1 && waddr1 != '0) begin
                model_mem[waddr1] = wdata1;
                model_pend[waddr1] = 1'b0;
            end
            if (we0 && waddr0 != '0) model_mem[waddr0] = wdata0;
            if (issue_valid && issue_addr != '0) model_pend[issue_addr] = 1'b1;
        end
        exp_q.push_back(DATA_W'($countones(model_pend)));
        exp_q.push_back(DATA_W'(model_conf));
        #1;
        check("pending_count", DATA_W'(pending_count));
        check("conflict_err", DATA_W'(conflict_err));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
        model_pend = '0;
        model_conf = 1'b0;
        idle();
        rd_addr = '0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // reset state at address 5
        set_rd(0, 5); set_rd(1, 5);
        check_port("rst_p0", 0);
        check_port("rst_p1", 1);

        // bypass of port 0, then stored value
        we0 = 1; waddr0 = 3; wdata0 = 32'hDEADBEEF; set_rd(0, 3);
        check_port("byp0", 0);
        tick();
        idle();
        check_port("stored3", 0);

        // zero register ignores writes and issues
        set_rd(0, 0);
        we0 = 1; waddr0 = 0; wdata0 = 32'h1234;
        check_port("zero_we0", 0);
        tick();
        idle(); we1 = 1; waddr1 = 0; wdata1 = 32'h1234;
        check_port("zero_we1", 0);
        tick();
        idle(); issue_valid = 1; issue_addr = 0;
        tick();
        idle();
        check_port("zero_after", 0);

        // same-register write conflict
        set_rd(1, 7);
        we0 = 1; waddr0 = 7; wdata0 = 32'hAAAA;
        we1 = 1; waddr1 = 7; wdata1 = 32'h5555;
        check_port("conf_byp", 1);
        tick();
        idle();
        check_port("conf_stored", 1);
        tick();
        tick();

        // pending counter sequence
        set_rd(0, 4); set_rd(1, 9);
        issue_valid = 1; issue_addr = 4;
        tick(); idle();
        check_port("pend4", 0);
        issue_valid = 1; issue_addr = 9;
        tick(); idle();
        check_port("pend9", 1);
        we1 = 1; waddr1 = 4; wdata1 = 32'h44; issue_valid = 1; issue_addr = 4;
        check_port("ret4_byp", 0);
        tick(); idle();
        check_port("pend4_kept", 0);
        we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        tick(); idle();
        check_port("pend9_clr", 1);
        we1 = 1; waddr1 = 4; wdata1 = 32'h4444;
        tick(); idle();
        check_port("pend4_clr", 0);

        // reset discards in-flight loads
        issue_valid = 1; issue_addr = 2; tick();
        issue_addr = 6; tick(); idle();
        set_rd(0, 2); set_rd(1, 3);
        check_port("pend2", 0);
        reset = 1;
        check_port("rst_force", 1);
        tick();
        reset = 0;
        set_rd(1, 6);
        check_port("post_rst2", 0);
        check_port("post_rst6", 1);
        we1 = 1; waddr1 = 2; wdata1 = 32'h77;
        tick(); idle();
        check_port("late_we1", 0);

        // randomised traffic against the model
        for (int n = 0; n < 40; n++) begin
            we0 = 1'($urandom_range(0, 1)); waddr0 = ADDR_W'($urandom_range(0, 7));
            wdata0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); waddr1 = ADDR_W'($urandom_range(0, 7));
            wdata1 = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr = ADDR_W'($urandom_range(0, 7));
            set_rd(0, ADDR_W'($urandom_range(0, 7)));
            set_rd(1, ADDR_W'($urandom_range(0, 7)));
            check_port("rnd_p0", 0);
            check_port("rnd_p1", 1);
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath; the next generation of the single-write, dual-read bank.
- Provides NUM_RD combinational read ports, two write ports (port 0: ALU writeback, port 1: load return), hardwired zero register and write-to-read bypass.
- Adds a per-register pending scoreboard for in-flight loads, with an outstanding-load counter and a sticky write-conflict flag.
- Writes on rising clk; the bypass replaces the old half-cycle negedge write.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, ≥ 2)
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing
- rd_pending  out  NUM_RD  pending bit of each addressed register
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load return; clears pending)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- issue_valid  in  1  load issued; mark its destination pending
- issue_addr  in  ADDR_W  load destination register
- pending_count  out  ADDR_W+1  number of set pending bits
- conflict_err  out  1  sticky: both write ports hit the same register in one cycle

Behaviour:
- Reset (synchronous, active-high, reset high at a rising edge):
  - All registers, pending bits, pending_count and conflict_err become 0 at that edge.
  - Writes and issues in that cycle are discarded.
  - While reset is high, rd_data and rd_pending are forced to 0 combinationally.
  - Reset asserted mid-operation discards any in-flight loads; their later we1 writes are ordinary writes.
- Reads are combinational, 0-cycle latency. Per port, in priority order:
  - ZERO_REG=1 and addr 0 → data 0, pending 0.
  - Else we0 && waddr0==addr → wdata0 (bypass).
  - Else we1 && waddr1==addr → wdata1 (bypass).
  - Else stored value.
- rd_pending reflects registered state only, not same-cycle set/clear; a same-cycle we1 to the address still returns the bypassed data.
- Writes take effect at the rising edge.
  - Both enables with the same non-zero address: port 0 data is stored and conflict_err sets (sticky until reset).
  - Different addresses: both write.
  - With ZERO_REG=1, writes to addr 0 are ignored and never raise conflict_err.
- Scoreboard, evaluated at the rising edge:
  - issue_valid sets pending[issue_addr].
  - we1 clears pending[waddr1].
  - Same register set and cleared in one cycle: set wins; the new load supersedes the returning one.
  - we0 does not touch pending.
  - issue_valid to an already pending register: stays set; counter unchanged.
  - Issue to addr 0 (ZERO_REG=1): ignored.
- pending_count is registered and equals popcount(pending) after every edge.
  - Update delta is +1, 0 or −1 per cycle from set/clear resolution; no full recount.
  - Range 0..NUM_REGS, so wrap is impossible.
  - The bench checks the equality invariant every cycle.
- No X propagation: every storage element is reset; out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - the default DATA_W / NUM_REGS constants;
  - a localparam for port priority (PORT0_WINS = 1);
  - a function for packed-port slicing.
- One natural sub-module: regfile_scoreboard, containing the pending vector, pending_count and the set/clear resolution.
- Storage, bypass muxes and conflict detection stay in regfile_bypass.

Test Plan:
- Reset then read all ports at addr 5 → rd_data 0, rd_pending 0, pending_count 0, conflict_err 0.
- we0=1, waddr0=3, wdata0=0xDEADBEEF with rd_addr[0]=3 in the same cycle → rd_data[0]=0xDEADBEEF combinationally; after the edge, with we0=0, it still reads 0xDEADBEEF.
- Write 0x1234 to addr 0 via each port, then issue_valid to 0 → reads 0, pending_count 0, conflict_err 0.
- Same cycle we0 (addr 7, 0xAAAA) and we1 (addr 7, 0x5555) → port 7 bypass shows 0xAAAA; after the edge reg7=0xAAAA and conflict_err=1; it stays 1 until reset.
- Pending-counter sequence:
  - Issue to 4 → rd_pending=1, count 1.
  - Issue to 9 → count 2.
  - we1 to 4 together with issue to 4 → pending[4] stays 1, count 2.
  - we1 to 9 → count 1.
  - we1 to 4 → count 0.
- Pending bits at 2 and 6, then reset for one cycle → all pending 0, count 0.
  - A later we1 to 2 with 0x77 is stored normally; count stays 0.
